// File: rtl/product_bcd_pkg.sv
// Shared definitions for the binary-product to BCD converter.
//   state_e        : converter FSM state encoding
//   BCD_ADJ_THRESH : digit value at or above which double-dabble adds 3
package product_bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int unsigned BCD_ADJ_THRESH = 5;

endpackage

// File: rtl/product_bcd_conv_if.sv
// Handshake bus between the multiplier, the BCD converter and the display stage.
//   bin_in/in_valid/in_ready          : binary product input handshake
//   bcd_out/out_valid/out_ready       : packed BCD result handshake
//   digit_blank                       : per-digit leading-zero blank flags
// Modports: slave = converter side, master = producer/consumer side.
interface product_bcd_conv_if #(
  parameter int unsigned BIN_W  = 8,
  parameter int unsigned DIGITS = 3
);

  logic [BIN_W-1:0]    bin_in;
  logic                in_valid;
  logic                in_ready;
  logic [4*DIGITS-1:0] bcd_out;
  logic                out_valid;
  logic                out_ready;
  logic [DIGITS-1:0]   digit_blank;

  modport slave (
    input  bin_in, in_valid, out_ready,
    output in_ready, bcd_out, out_valid, digit_blank
  );

  modport master (
    output bin_in, in_valid, out_ready,
    input  in_ready, bcd_out, out_valid, digit_blank
  );

endinterface

// File: rtl/bcd_add3.sv
// Combinational double-dabble digit adjust: adds 3 to a BCD digit >= 5.
//   digit : 4-bit BCD digit before the shift
//   adj_c : adjusted digit (combinational)
module bcd_add3
  import product_bcd_pkg::*;
(
  input  logic [3:0] digit,
  output logic [3:0] adj_c
);

  assign adj_c = (digit >= 4'(BCD_ADJ_THRESH)) ? digit + 4'd3 : digit;

endmodule

// File: rtl/product_bcd_conv.sv
// Sequential double-dabble converter from an unsigned binary product to BCD.
// One bit is shifted per cycle; the result is published once, after all
// BIN_W shifts, so bcd_out never shows a partial conversion.
//   clk : rising-edge clock
//   clr : synchronous active-high reset
//   bus : product_bcd_conv_if.slave (bin_in/in_valid/in_ready,
//         bcd_out/out_valid/out_ready, digit_blank)
// Optional feature: define BCD_LEADING_ZERO_BLANK_EN to produce registered
// leading-zero blank flags; otherwise digit_blank is tied to zero.
module product_bcd_conv
  import product_bcd_pkg::*;
#(
  parameter int unsigned BIN_W  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                clk,
  input  logic                clr,
  product_bcd_conv_if.slave   bus
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned CNT_W = $clog2(BIN_W + 1);

  state_e             state;
  logic [BCD_W-1:0]   scratch;
  logic [BCD_W-1:0]   scratch_adj;
  logic [BCD_W-1:0]   bcd_q;
  logic [BIN_W-1:0]   bin_q;
  logic [CNT_W-1:0]   cnt;
  logic               in_ready_q;
  logic               out_valid_q;
  logic               done_load;

  // Per-digit add-3 adjust applied before every shift
  for (genvar g = 0; g < int'(DIGITS); g++) begin : g_adj
    bcd_add3 u_add3 (
      .digit (scratch[4*g +: 4]),
      .adj_c (scratch_adj[4*g +: 4])
    );
  end

  // Last SHIFT cycle: all bits consumed, result is published on this edge
  assign done_load = (state == SHIFT) && (cnt == '0);

  // Converter FSM with registered handshake outputs
  always_ff @(posedge clk) begin
    if (clr) begin
      state       <= IDLE;
      scratch     <= '0;
      bin_q       <= '0;
      cnt         <= '0;
      bcd_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            bin_q      <= bus.bin_in;
            cnt        <= CNT_W'(BIN_W);
            scratch    <= '0;
            in_ready_q <= 1'b0;
            state      <= SHIFT;
          end
        end
        SHIFT: begin
          if (cnt == '0) begin
            bcd_q       <= scratch;
            out_valid_q <= 1'b1;
            state       <= DONE;
          end else begin
            // {scratch, bin_q} shifted left as one register
            scratch <= {scratch_adj[BCD_W-2:0], bin_q[BIN_W-1]};
            bin_q   <= bin_q << 1;
            cnt     <= cnt - CNT_W'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.bcd_out   = bcd_q;

`ifdef BCD_LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] blank_c;
  logic [DIGITS-1:0] blank_q;

  // Blank digit i when it and every digit above it are zero; units never blank
  always_comb begin
    logic zero_run;
    blank_c  = '0;
    zero_run = 1'b1;
    for (int i = int'(DIGITS) - 1; i > 0; i--) begin
      zero_run   = zero_run && (scratch[4*i +: 4] == 4'd0);
      blank_c[i] = zero_run;
    end
  end

  // Captured on the same edge as bcd_out so both always match
  always_ff @(posedge clk) begin
    if (clr) begin
      blank_q <= '0;
    end else if (done_load) begin
      blank_q <= blank_c;
    end
  end

  assign bus.digit_blank = blank_q;
`else
  logic unused_done_load;
  assign unused_done_load = done_load;
  assign bus.digit_blank  = '0;
`endif

endmodule

// File: tb/tb_product_bcd_conv.sv
// Self-checking bench for product_bcd_conv: table vectors, random vectors
// against a divide-by-ten model, plus stall, back-to-back and mid-conversion
// reset sequences. Expected results go through a scoreboard queue.
module tb_product_bcd_conv;

  localparam int unsigned BIN_W  = 8;
  localparam int unsigned DIGITS = 3;
  localparam int unsigned LAT    = BIN_W + 1;

  typedef struct packed {
    logic [11:0] bcd;
    logic [2:0]  blank;
  } exp_t;

  typedef struct {
    logic [7:0]  bin;
    logic [11:0] bcd;
    logic [2:0]  blank;
  } vec_t;

  logic clk = 1'b0;
  logic clr;
  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb[$];
  vec_t vecs[9];

  always #5 clk = ~clk;

  product_bcd_conv_if #(.BIN_W(BIN_W), .DIGITS(DIGITS)) bus ();

  product_bcd_conv #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus.slave)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Blank flags only exist when the feature is compiled in
  function automatic logic [2:0] eff_blank(input logic [2:0] b);
`ifdef BCD_LEADING_ZERO_BLANK_EN
    return b;
`else
    return 3'b000 & b;
`endif
  endfunction

  function automatic exp_t model(input int v);
    exp_t e;
    e.bcd   = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    e.blank = eff_blank({v < 100, v < 10, 1'b0});
    return e;
  endfunction

  // Offer one value and push its expected result; returns after the accept edge
  task automatic send(input logic [7:0] b, input exp_t e);
    int n = 0;
    while (bus.in_ready !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    check("in_ready_before_send", 32'(bus.in_ready), 32'd1);
    bus.bin_in   = b;
    bus.in_valid = 1'b1;
    sb.push_back(e);
    step();
    bus.in_valid = 1'b0;
    bus.bin_in   = 8'($urandom);
    check("in_ready_after_accept", 32'(bus.in_ready), 32'd0);
  endtask

  // Wait for the result, check latency and value, then complete the handshake
  task automatic collect(input string nm, input bit hold);
    int   lat = 0;
    exp_t e;
    logic [11:0] got;
    do begin
      step();
      lat++;
    end while (bus.out_valid !== 1'b1 && lat < 40);
    check({nm, "_latency"}, 32'(lat), 32'(LAT));
    if (sb.size() == 0) begin
      check({nm, "_scoreboard_empty"}, 32'd1, 32'd0);
      e = '0;
    end else begin
      e = sb.pop_front();
    end
    got = bus.bcd_out;
    check({nm, "_bcd"}, 32'(bus.bcd_out), 32'(e.bcd));
    check({nm, "_blank"}, 32'(bus.digit_blank), 32'(e.blank));
    bus.out_ready = 1'b1;
    step();
    if (!hold) bus.out_ready = 1'b0;
    check({nm, "_out_valid_drop"}, 32'(bus.out_valid), 32'd0);
    check({nm, "_in_ready_back"}, 32'(bus.in_ready), 32'd1);
    check({nm, "_bcd_held"}, 32'(bus.bcd_out), 32'(got));
  endtask

  initial begin
    vecs[0] = '{8'd0,   12'h000, 3'b110};
    vecs[1] = '{8'd225, 12'h225, 3'b000};
    vecs[2] = '{8'd255, 12'h255, 3'b000};
    vecs[3] = '{8'd7,   12'h007, 3'b110};
    vecs[4] = '{8'd1,   12'h001, 3'b110};
    vecs[5] = '{8'd10,  12'h010, 3'b100};
    vecs[6] = '{8'd100, 12'h100, 3'b000};
    vecs[7] = '{8'd99,  12'h099, 3'b100};
    vecs[8] = '{8'd59,  12'h059, 3'b100};

    clr           = 1'b1;
    bus.bin_in    = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) step();
    check("reset_in_ready", 32'(bus.in_ready), 32'd1);
    check("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check("reset_bcd", 32'(bus.bcd_out), 32'd0);
    check("reset_blank", 32'(bus.digit_blank), 32'd0);
    clr = 1'b0;
    check("release_in_ready", 32'(bus.in_ready), 32'd1);

    // Table vectors
    for (int i = 0; i < 9; i++) begin
      exp_t e;
      e.bcd   = vecs[i].bcd;
      e.blank = eff_blank(vecs[i].blank);
      send(vecs[i].bin, e);
      collect($sformatf("vec%0d", i), 1'b0);
    end

    // Random vectors against the arithmetic model
    for (int i = 0; i < 8; i++) begin
      int v;
      v = int'($urandom_range(0, 255));
      send(8'(v), model(v));
      collect($sformatf("rnd%0d", i), 1'b0);
    end

    // Consumer stall with a new value pending on the input
    send(8'd123, model(123));
    begin
      int lat = 0;
      do begin
        step();
        lat++;
      end while (bus.out_valid !== 1'b1 && lat < 40);
      check("stall_latency", 32'(lat), 32'(LAT));
    end
    bus.bin_in   = 8'd77;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      check("stall_out_valid", 32'(bus.out_valid), 32'd1);
      check("stall_in_ready", 32'(bus.in_ready), 32'd0);
      check("stall_bcd", 32'(bus.bcd_out), 32'h123);
    end
    void'(sb.pop_front());
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check("stall_release_out_valid", 32'(bus.out_valid), 32'd0);
    check("stall_release_in_ready", 32'(bus.in_ready), 32'd1);
    sb.push_back(model(77));
    step();
    bus.in_valid = 1'b0;
    check("stall_accept_next", 32'(bus.in_ready), 32'd0);
    collect("stall_next", 1'b0);

    // Back-to-back with out_ready held high throughout
    bus.out_ready = 1'b1;
    send(8'd1, model(1));
    collect("b2b_1", 1'b1);
    send(8'd10, model(10));
    collect("b2b_10", 1'b1);
    send(8'd100, model(100));
    collect("b2b_100", 1'b1);
    bus.out_ready = 1'b0;

    // Reset in the 4th SHIFT cycle discards the conversion
    bus.bin_in   = 8'd99;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    repeat (3) step();
    clr = 1'b1;
    bus.in_valid = 1'b1;
    step();
    check("clr_mid_in_ready", 32'(bus.in_ready), 32'd1);
    check("clr_mid_out_valid", 32'(bus.out_valid), 32'd0);
    check("clr_mid_bcd", 32'(bus.bcd_out), 32'd0);
    check("clr_mid_blank", 32'(bus.digit_blank), 32'd0);
    // Held reset beats in_valid in IDLE
    step();
    check("clr_priority_in_ready", 32'(bus.in_ready), 32'd1);
    clr          = 1'b0;
    bus.in_valid = 1'b0;
    repeat (12) step();
    check("clr_no_stale_result", 32'(bus.out_valid), 32'd0);
    send(8'd42, model(42));
    collect("after_clr_42", 1'b0);

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/product_bcd_conv.md
PRODUCT_BCD_CONV -- requirements
Module: product_bcd_conv

Interface
REQ-001 SHALL have parameter BIN_W, default 8: binary input width; matches the 8-bit multiplier product.
REQ-002 SHALL have parameter DIGITS, default 3: BCD output digit count; 10^DIGITS > 2^BIN_W is required.
REQ-003 SHALL have port clk  input  1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port clr  input  1: reset, synchronous, active-high.
REQ-005 SHALL have port bin_in  input  BIN_W: unsigned binary value (multiplier product).
REQ-006 SHALL have port in_valid  input  1: bin_in is valid this cycle.
REQ-007 SHALL have port in_ready  output  1: converter can accept bin_in this cycle.
REQ-008 SHALL have port bcd_out  output  4*DIGITS: packed BCD result; digit 0 (units) in bits [3:0].
REQ-009 SHALL have port out_valid  output  1: bcd_out holds a completed conversion.
REQ-010 SHALL have port out_ready  input  1: consumer (display stage) accepts bcd_out.
REQ-011 SHALL have port digit_blank  output  DIGITS: per-digit leading-zero blank flag.

Function
REQ-012 SHALL implement FSM states IDLE, SHIFT and DONE.
REQ-013 In IDLE, in_ready SHALL be 1; in_valid=1 SHALL capture bin_in, load shift counter with BIN_W, clear the BCD scratch register and go to SHIFT (accept cycle).
REQ-014 SHALL keep in_ready at 0 in SHIFT and DONE; in_valid in those states SHALL be ignored, and bin_in need not be held.
REQ-015 Each SHIFT cycle SHALL add 3 to every scratch digit >= 5, then shift {scratch, binary} left one bit (double-dabble) and decrement the counter.
REQ-016 When the counter reaches 0, the FSM SHALL copy the scratch register to bcd_out and enter DONE; out_valid SHALL rise exactly BIN_W+1 cycles after the accept edge.
REQ-017 In DONE, out_valid SHALL be 1; out_ready=1 SHALL return to IDLE the next cycle; out_valid=0 and in_ready=1 SHALL follow from that cycle.
REQ-018 bcd_out SHALL hold its value until the next completion, including after the handshake; it SHALL never show partial results.
REQ-019 Each BCD digit SHALL always be in the range 0..9; the maximum input 2^BIN_W-1 SHALL convert exactly.
REQ-020 out_ready asserted outside DONE SHALL have no effect.

Reset
REQ-021 clr=1 SHALL, on the next rising edge and in any state (including mid-SHIFT), force IDLE, zero bcd_out, scratch, binary and counter, and set out_valid=0 and digit_blank=0; the aborted conversion SHALL be discarded.
REQ-022 clr SHALL take priority over in_valid and out_ready in the same cycle.
REQ-023 After reset release, in_ready SHALL be 1 in the first cycle.

Configuration
REQ-024 Macro BCD_LEADING_ZERO_BLANK_EN defined: digit_blank SHALL be registered with bcd_out; bit i SHALL be 1 iff digits DIGITS-1..i are all zero and i>0; digit 0 SHALL never be blanked.
REQ-025 Macro BCD_LEADING_ZERO_BLANK_EN undefined: digit_blank SHALL be tied to 0 and no blank logic SHALL be synthesised.

Structure
REQ-026 Shared package product_bcd_pkg SHALL hold the FSM state encoding (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) and the constant BCD_ADJ_THRESH=5.
REQ-027 Sub-module bcd_add3 (combinational 4-bit digit adjust: output = in+3 if in>=5, else in) SHALL be instantiated DIGITS times.

Verification
REQ-028 Reset, then send bin_in=0 -> out_valid after 9 cycles; bcd_out=12'h000; digit_blank=3'b110 (blank enabled).
REQ-029 bin_in=225 (15x15) -> bcd_out=12'h225, digit_blank=3'b000; bin_in=255 -> 12'h255.
REQ-030 bin_in=7 with blank enabled -> bcd_out=12'h007, digit_blank=3'b110; with blank disabled -> digit_blank=3'b000.
REQ-031 out_ready=0 for 20 cycles after completion while in_valid=1 with a new value -> out_valid stays 1, bcd_out unchanged, in_ready=0; then out_ready=1 -> IDLE, new value accepted the next cycle.
REQ-032 bin_in=99, clr pulsed in the 4th SHIFT cycle -> next cycle: IDLE, bcd_out=0, out_valid=0; a fresh bin_in=42 then yields 12'h042.
REQ-033 Back-to-back products 1, 10, 100 with out_ready held at 1 -> results 001, 010, 100, each BIN_W+1 cycles after its accept edge.
